// File: rtl/rat_intc_pkg.sv
// Shared types and helpers for the RAT interrupt controller.
package rat_intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] MASK_OFS = 2'd0;
    localparam logic [1:0] PEND_OFS = 2'd1;
    localparam logic [1:0] STAT_OFS = 2'd2;
    localparam logic [1:0] EOI_OFS  = 2'd3;

    // Index of the lowest set bit; bit 0 has the highest priority.
    function automatic logic [4:0] prio_enc(input logic [31:0] req);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (req[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rat_intc_edge.sv
// Per-source rising-edge detector; RAT_INTC_SYNC_EN adds a 2-flop synchroniser
// in front of the detector for asynchronous IRQ sources.
module rat_intc_edge #(
    parameter int N_SRC = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_irq,
    output logic [N_SRC-1:0] o_edge
);

    logic [N_SRC-1:0] w_irq;
    logic [N_SRC-1:0] r_prev;

`ifdef RAT_INTC_SYNC_EN
    logic [N_SRC-1:0] r_sync1;
    logic [N_SRC-1:0] r_sync2;

    // Two-stage synchroniser for metastability settling.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq = r_sync2;
`else
    assign w_irq = i_irq;
`endif

    // Edge history: one sample behind the (possibly synchronised) input.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_irq;
        end
    end

    assign o_edge = w_irq & ~r_prev;

endmodule

// File: rtl/rat_intc.sv
// RAT interrupt controller: pending/mask registers, fixed-priority arbitration
// and the INT_CU request/ack/EOI handshake. Optional macro: RAT_INTC_SYNC_EN.
module rat_intc
    import rat_intc_pkg::*;
#(
    parameter int         N_SRC   = 8,
    parameter int         DATA_W  = 8,
    parameter logic [7:0] BASE_ID = 8'hF0,
    localparam int        VEC_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [N_SRC-1:0]  IRQ_IN,
    input  logic [7:0]        PORT_ID,
    input  logic [DATA_W-1:0] OUT_PORT,
    input  logic              IO_STRB,
    input  logic              INT_ACK,
    output logic              INT_CU,
    output logic [VEC_W-1:0]  INT_VEC,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_HIT
);

    logic [N_SRC-1:0]  w_edge;
    logic [N_SRC-1:0]  r_mask;
    logic [N_SRC-1:0]  r_pend;
    logic [N_SRC-1:0]  w_elig;
    logic [N_SRC-1:0]  w_w1c;
    logic [N_SRC-1:0]  w_ack_clr;
    logic [7:0]        w_ofs;
    logic              w_in_map;
    logic              w_wr_mask;
    logic              w_wr_pend;
    logic              w_wr_eoi;
    logic [VEC_W-1:0]  w_win;
    logic              w_vec_elig;
    logic [DATA_W-1:0] w_rd;
    state_t            r_state;
    logic [VEC_W-1:0]  r_vec;
    logic              r_int_cu;

    rat_intc_edge #(.N_SRC(N_SRC)) u_edge (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_irq  (IRQ_IN),
        .o_edge (w_edge)
    );

    assign w_ofs      = PORT_ID - BASE_ID;
    assign w_in_map   = (w_ofs < 8'd4);
    assign w_wr_mask  = IO_STRB && w_in_map && (w_ofs[1:0] == MASK_OFS);
    assign w_wr_pend  = IO_STRB && w_in_map && (w_ofs[1:0] == PEND_OFS);
    assign w_wr_eoi   = IO_STRB && w_in_map && (w_ofs[1:0] == EOI_OFS);
    assign w_elig     = r_pend & r_mask;
    assign w_win      = VEC_W'(prio_enc(32'(w_elig)));
    assign w_vec_elig = w_elig[r_vec];
    assign w_w1c      = w_wr_pend ? OUT_PORT[N_SRC-1:0] : '0;

    // Acknowledge retires the latched vector's pending bit.
    always_comb begin
        w_ack_clr = '0;
        if ((r_state == ST_REQ) && INT_ACK) begin
            w_ack_clr[r_vec] = 1'b1;
        end else begin
            w_ack_clr = '0;
        end
    end

    // Mask and pending registers; a new edge always beats a same-cycle clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_mask <= '0;
            r_pend <= '0;
        end else begin
            if (w_wr_mask) begin
                r_mask <= OUT_PORT[N_SRC-1:0];
            end else begin
                r_mask <= r_mask;
            end
            r_pend <= (r_pend & ~(w_w1c | w_ack_clr)) | w_edge;
        end
    end

    // Handshake FSM; INT_VEC stays latched for the whole request and service.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= ST_IDLE;
            r_vec    <= '0;
            r_int_cu <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_elig) begin
                        r_vec    <= w_win;
                        r_int_cu <= 1'b1;
                        r_state  <= ST_REQ;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (INT_ACK) begin
                        r_int_cu <= 1'b0;
                        r_state  <= ST_SERVICE;
                    end else if (!w_vec_elig) begin
                        r_int_cu <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_state  <= ST_REQ;
                    end
                end
                ST_SERVICE: begin
                    if (w_wr_eoi) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_SERVICE;
                    end
                end
                default: begin
                    r_int_cu <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Combinational register read for the MCU IN_PORT mux.
    always_comb begin
        w_rd = '0;
        case (w_ofs)
            8'd0: w_rd[N_SRC-1:0] = r_mask;
            8'd1: w_rd[N_SRC-1:0] = r_pend;
            8'd2: begin
                w_rd[VEC_W-1:0]  = r_vec;
                w_rd[DATA_W-1]   = (r_state == ST_SERVICE);
            end
            default: w_rd = '0;
        endcase
    end

    assign RD_HIT  = (w_ofs < 8'd3);
    assign RD_DATA = w_rd;
    assign INT_CU  = r_int_cu;
    assign INT_VEC = r_vec;

endmodule

// File: tb/tb_rat_intc.sv
// Self-checking bench for rat_intc: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_rat_intc;

`ifdef RAT_INTC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] IRQ_IN = 8'h00;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic       IO_STRB = 1'b0;
    logic       INT_ACK = 1'b0;
    logic       INT_CU;
    logic [2:0] INT_VEC;
    logic [7:0] RD_DATA;
    logic       RD_HIT;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: mode 0 = idle, 1 = requesting, 2 = in service.
    int m_mask, m_pend, m_mode, m_vec, m_cu;
    int hist [0:3];

    rat_intc #(.N_SRC(8), .DATA_W(8), .BASE_ID(8'hF0)) dut (
        .CLK(CLK), .RESET(RESET), .IRQ_IN(IRQ_IN), .PORT_ID(PORT_ID),
        .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .INT_ACK(INT_ACK),
        .INT_CU(INT_CU), .INT_VEC(INT_VEC), .RD_DATA(RD_DATA), .RD_HIT(RD_HIT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_off(input int port);
        return (port - 240) & 255;
    endfunction

    function automatic int m_read(input int port);
        case (m_off(port))
            0: return m_mask;
            1: return m_pend;
            2: return ((m_mode == 2) ? 128 : 0) | m_vec;
            default: return 0;
        endcase
    endfunction

    function automatic int m_hit(input int port);
        return (m_off(port) < 3) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_mask = 0; m_pend = 0; m_mode = 0; m_vec = 0; m_cu = 0;
        for (int i = 0; i < 4; i++) hist[i] = 0;
    endtask

    task automatic model_step();
        int cur, prv, edg, off, clr, elig;
        bit wr;
        if (RESET) begin
            model_reset();
            return;
        end
        cur = (LAT == 0) ? int'(IRQ_IN) : hist[LAT-1];
        prv = hist[LAT];
        edg = cur & ~prv & 255;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(IRQ_IN);
        off  = m_off(int'(PORT_ID));
        wr   = IO_STRB && (off < 4);
        clr  = 0;
        elig = m_pend & m_mask;
        case (m_mode)
            0: if (elig != 0) begin
                   for (int i = 7; i >= 0; i--) if (((elig >> i) & 1) == 1) m_vec = i;
                   m_cu = 1; m_mode = 1;
               end
            1: if (INT_ACK) begin
                   clr = 1 << m_vec; m_cu = 0; m_mode = 2;
               end else if (((elig >> m_vec) & 1) == 0) begin
                   m_cu = 0; m_mode = 0;
               end
            default: if (wr && off == 3) m_mode = 0;
        endcase
        if (wr && off == 1) clr = clr | int'(OUT_PORT);
        if (wr && off == 0) m_mask = int'(OUT_PORT);
        m_pend = ((m_pend & ~clr) | edg) & 255;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge CLK) begin
        chk("int_cu",  int'(INT_CU),  m_cu);
        chk("int_vec", int'(INT_VEC), m_vec);
        chk("rd_hit",  int'(RD_HIT),  m_hit(int'(PORT_ID)));
        chk("rd_data", int'(RD_DATA), m_read(int'(PORT_ID)));
    end

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [7:0] port, input logic [7:0] data);
        PORT_ID = port; OUT_PORT = data; IO_STRB = 1'b1;
        tick();
        IO_STRB = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] port, input int exp);
        PORT_ID = port;
        #1;
        chk(name, int'(RD_DATA), exp);
    endtask

    task automatic ack();
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
    endtask

    initial begin
        model_reset();
        tick(); tick();
        RESET = 1'b0;
        tick();
        rd_chk("rst_mask", 8'hF0, 0);
        rd_chk("rst_pend", 8'hF1, 0);
        rd_chk("rst_stat", 8'hF2, 0);
        chk("rst_cu", int'(INT_CU), 0);

        // Single source, full handshake.
        wr(8'hF0, 8'h04);
        IRQ_IN = 8'h04; tick(); repeat (LAT) tick();
        rd_chk("p2_pend", 8'hF1, 8'h04);
        chk("p2_cu_early", int'(INT_CU), 0);
        IRQ_IN = 8'h00; tick();
        chk("p2_cu", int'(INT_CU), 1);
        chk("p2_vec", int'(INT_VEC), 2);
        ack();
        rd_chk("p2_pend_ack", 8'hF1, 8'h00);
        rd_chk("p2_stat_svc", 8'hF2, 8'h82);
        chk("p2_cu_svc", int'(INT_CU), 0);
        wr(8'hF3, 8'h00);
        rd_chk("p2_stat_eoi", 8'hF2, 8'h02);
        tick();
        chk("p2_cu_eoi", int'(INT_CU), 0);

        // Priority between two simultaneous sources.
        wr(8'hF0, 8'hFF);
        IRQ_IN = 8'h22; tick(); repeat (LAT) tick();
        IRQ_IN = 8'h00; tick();
        chk("pri_cu", int'(INT_CU), 1);
        chk("pri_vec1", int'(INT_VEC), 1);
        ack(); wr(8'hF3, 8'h00); tick();
        chk("pri_cu2", int'(INT_CU), 1);
        chk("pri_vec5", int'(INT_VEC), 5);
        ack(); wr(8'hF3, 8'h00);

        // Masked pending, then unmask.
        wr(8'hF0, 8'h00);
        IRQ_IN = 8'h08; tick(); repeat (LAT) tick();
        IRQ_IN = 8'h00;
        rd_chk("msk_pend", 8'hF1, 8'h08);
        tick();
        chk("msk_cu0", int'(INT_CU), 0);
        wr(8'hF0, 8'h08); tick();
        chk("msk_cu1", int'(INT_CU), 1);
        chk("msk_vec", int'(INT_VEC), 3);

        // W1C withdraws the request without an ack.
        wr(8'hF1, 8'h08);
        chk("w1c_cu_hold", int'(INT_CU), 1);
        tick();
        chk("w1c_cu_drop", int'(INT_CU), 0);
        rd_chk("w1c_pend", 8'hF1, 8'h00);
        rd_chk("w1c_stat", 8'hF2, 8'h03);

        // Edge and W1C in the same cycle: the set wins.
        IRQ_IN = 8'h08; repeat (LAT) tick();
        wr(8'hF1, 8'h08);
        rd_chk("set_wins", 8'hF1, 8'h08);
        tick();
        chk("set_wins_cu", int'(INT_CU), 1);

        // Asynchronous reset in REQ.
        RESET = 1'b1;
        #1;
        chk("arst_cu", int'(INT_CU), 0);
        rd_chk("arst_stat", 8'hF2, 0);
        rd_chk("arst_pend", 8'hF1, 0);
        model_reset();
        IRQ_IN = 8'h00;
        tick();
        RESET = 1'b0;
        tick();

        // Randomized traffic checked by the per-cycle comparator.
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) IRQ_IN[b] = ~IRQ_IN[b];
            if ($urandom_range(0, 5) == 0) PORT_ID = 8'($urandom);
            else PORT_ID = 8'(8'hF0 + $urandom_range(0, 3));
            OUT_PORT = 8'($urandom);
            IO_STRB  = ($urandom_range(0, 4) == 0);
            INT_ACK  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                RESET = 1'b1;
                #1;
                chk("rnd_arst_cu", int'(INT_CU), 0);
                model_reset();
                tick();
                RESET = 1'b0;
            end
            tick();
        end
        IO_STRB = 1'b0; INT_ACK = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rat_intc.md
Name: rat_intc

Overview:
- Parametrised, port-mapped interrupt controller for the RAT MCU.
- Sits between N external interrupt sources and the control unit's single INT_CU input.
- Edge-detects each source, latches pending bits, applies a software mask and selects a fixed-priority winner.
- Runs a request/acknowledge/end-of-interrupt handshake with the CU and exposes its registers on the RAT PORT_ID / OUT_PORT / IO_STRB bus.

Parameters:
- N_SRC, 8, number of interrupt sources; legal range 1..DATA_W.
- DATA_W, 8, I/O data width; matches the RAT port width.
- BASE_ID, 8'hF0, PORT_ID of register 0. Registers occupy BASE_ID..BASE_ID+3.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IRQ_IN  in  N_SRC  raw interrupt sources; rising edge requests service.
- PORT_ID  in  8  I/O address from the MCU.
- OUT_PORT  in  DATA_W  write data from the MCU.
- IO_STRB  in  1  one-cycle write strobe from the MCU.
- INT_ACK  in  1  CU pulse: interrupt accepted and vectoring has begun.
- INT_CU  out  1  interrupt request to the CU.
- INT_VEC  out  $clog2(N_SRC) (min 1)  index of the source being requested or serviced.
- RD_DATA  out  DATA_W  combinational register read data, for the IN_PORT mux.
- RD_HIT  out  1  PORT_ID is within BASE_ID..BASE_ID+2.

Behaviour:
- Reset (asynchronous, immediate): MASK=0, PEND=0, edge-history=0, state IDLE, INT_CU=0, INT_VEC=0. Reset mid-handshake abandons the handshake with no residue.
- Edge detect: prev <= IRQ_IN every clock. edge = IRQ_IN & ~prev. PEND[i] is set at the clock edge where edge[i]=1, so latency is 1 clock from IRQ high at a sampling edge. A held-high level gives one event only.
- Register map (write on IO_STRB && PORT_ID match):
  - +0 MASK: read/write; 1 = enabled.
  - +1 PEND: read; write-1-to-clear.
  - +2 STATUS: read only; bit DATA_W-1 = in-service, low bits = INT_VEC.
  - +3 EOI: write only, data ignored.
- Bits at and above N_SRC read 0 and ignore writes.
- Eligible = PEND & MASK. Winner = lowest set index (bit 0 has highest priority).
- FSM IDLE:
  - If eligible is nonzero: latch INT_VEC = winner, go to REQ, and assert INT_CU from the next cycle.
- FSM REQ:
  - INT_CU=1; INT_VEC is held stable.
  - INT_ACK=1: clear PEND[INT_VEC], set INT_CU=0, go to SERVICE.
  - Eligible[INT_VEC] drops to 0 before the ack (masked or W1C): set INT_CU=0 and return to IDLE. Re-arbitration happens from IDLE on the following cycle.
  - A higher-priority source arriving while in REQ does not preempt the latched vector.
- FSM SERVICE:
  - INT_CU=0; new edges still latch into PEND.
  - Write to EOI: go to IDLE.
  - INT_ACK is ignored.
- EOI writes in IDLE or REQ are ignored. INT_ACK in IDLE is ignored.
- Simultaneous events on the same bit:
  - Edge and W1C in the same cycle: set wins.
  - Edge and INT_ACK clear in the same cycle: set wins, giving a new pending event.
- MASK write and an edge in the same cycle: the edge still latches into PEND; masking affects eligibility only.
- Read mux is purely combinational on PORT_ID. RD_DATA=0 when RD_HIT=0.

Optional Feature:
- Macro RAT_INTC_SYNC_EN.
- Defined: IRQ_IN passes through a 2-flop synchroniser before edge detection, so latency is 3 clocks from IRQ high to PEND set.
- Undefined: IRQ_IN is assumed synchronous to CLK and latency is 1 clock.
- Register map and FSM are identical in both builds.

Decomposition:
- Package rat_intc_pkg holds:
  - the state enum (IDLE, REQ, SERVICE);
  - register offset constants (MASK_OFS=0, PEND_OFS=1, STAT_OFS=2, EOI_OFS=3);
  - a priority-encoder function.
- One sub-module: rat_intc_edge, the per-source synchroniser plus edge detector, parametrised by N_SRC, containing the RAT_INTC_SYNC_EN logic.
- Arbitration, FSM and the register file live in rat_intc.

Test Plan:
- Reset, then read +0/+1/+2 → all 0x00; INT_CU=0. Assert RESET while in REQ → INT_CU drops immediately, state is IDLE.
- MASK=0x04, pulse IRQ_IN[2] → PEND=0x04 after 1 clock, INT_CU=1 with INT_VEC=2 the clock after. INT_ACK → PEND=0x00, STATUS=0x82. EOI write → STATUS=0x02, INT_CU stays 0.
- MASK=0xFF, raise IRQ_IN[5] and IRQ_IN[1] in the same cycle → INT_VEC=1. After ACK and EOI, a second request appears with INT_VEC=5.
- MASK=0x00, pulse IRQ_IN[3] → PEND=0x08, INT_CU=0. Write MASK=0x08 → INT_CU=1, INT_VEC=3.
- In REQ for source 3, write PEND W1C 0x08 → INT_CU returns to 0 without an ack. In a separate run, issue W1C 0x08 in the same cycle as a new IRQ_IN[3] edge → PEND bit stays 1.
- RAT_INTC_SYNC_EN defined: pulse IRQ_IN[0] high for 3 clocks → PEND[0] sets exactly 3 clocks after the first high sample, and only one event is latched.
